// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache between the CPU PC and instruction memory.
// Optional hit/miss statistics counters are enabled with `define ICACHE_STATS_EN.
module icache_fetch #(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_BITS  = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic                 MEM_READ,
    output logic [ADDR_BITS-5:0] MEM_ADDRESS,
    input  logic [127:0]         MEM_READDATA,
    input  logic                 MEM_BUSYWAIT,
`ifdef ICACHE_STATS_EN
    output logic [15:0]          HIT_COUNT,
    output logic [15:0]          MISS_COUNT,
`endif
    output logic [1:0]           DBG_STATE
);

    localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_READ = 2'd1;
    localparam logic [1:0] S_UPDATE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [INDEX_BITS-1:0] miss_index_q;
    logic [127:0]          fill_q;
    logic                  first_q;

    logic [1:0]            pc_offset;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  hit;
    logic [127:0]          line_data;
    logic                  unused_pc;

    assign pc_offset = PC[3:2];
    assign pc_index  = PC[3+INDEX_BITS:4];
    assign pc_tag    = PC[ADDR_BITS-1:4+INDEX_BITS];
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign line_data = data_q[pc_index];

    // Memory handshake: MEM_READ and MEM_ADDRESS stay stable for the whole
    // MEM_READ state; MEM_READDATA is taken at the first edge after the first
    // cycle of the state where MEM_BUSYWAIT is low.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (!hit) state_d = S_MEM_READ;
            S_MEM_READ: if (!first_q && !MEM_BUSYWAIT) state_d = S_UPDATE;
            S_UPDATE:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            fill_q       <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && !hit) begin
                miss_tag_q   <= pc_tag;
                miss_index_q <= pc_index;
                first_q      <= 1'b1;
            end
            if (state_q == S_MEM_READ) begin
                first_q <= 1'b0;
                if (state_d == S_UPDATE) fill_q <= MEM_READDATA;
            end
            if (state_q == S_UPDATE) valid_q[miss_index_q] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (state_q == S_UPDATE) begin
            tag_q[miss_index_q]  <= miss_tag_q;
            data_q[miss_index_q] <= fill_q;
        end
    end

    assign MEM_READ    = (state_q == S_MEM_READ);
    assign MEM_ADDRESS = MEM_READ ? {miss_tag_q, miss_index_q} : '0;
    assign INSTRUCTION = (state_q == S_IDLE && hit) ? line_data[{pc_offset, 5'd0} +: 32] : 32'h0;
    assign BUSYWAIT    = RESET && ((state_q != S_IDLE) || !hit);
    assign DBG_STATE   = state_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a behavioural instruction memory of
// configurable latency; word i of block a is i*32'h11111111 + (a << 16).
module tb_icache_fetch;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b0;
  logic [1:0]   DBG_STATE;
`ifdef ICACHE_STATS_EN
  logic [15:0]  HIT_COUNT;
  logic [15:0]  MISS_COUNT;
`endif

  int tests = 0;
  int fails = 0;
  int mem_lat = 5;
  int mem_cnt = 0;

  icache_fetch dut (
    .CLK(CLK),
    .RESET(RESET),
    .PC(PC),
    .INSTRUCTION(INSTRUCTION),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
`ifdef ICACHE_STATS_EN
    .HIT_COUNT(HIT_COUNT),
    .MISS_COUNT(MISS_COUNT),
`endif
    .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [127:0] blk(input logic [5:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++)
      b[32*i +: 32] = 32'h11111111 * i + ({26'b0, a} << 16);
    return b;
  endfunction

  // Memory model: busy for the first mem_lat-1 cycles of a request.
  always @(negedge CLK) begin
    if (MEM_READ) begin
      mem_cnt = mem_cnt + 1;
      MEM_BUSYWAIT = (mem_cnt < mem_lat);
      MEM_READDATA = blk(MEM_ADDRESS);
    end else begin
      mem_cnt = 0;
      MEM_BUSYWAIT = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered #1 after the edge that put the FSM in MEM_READ (or mid-state).
  task automatic run_fill(input logic [5:0] exp_addr, input int exp_cycles);
    int n = 0;
    while (MEM_READ && n < 50) begin
      chk("fill_addr", {26'b0, MEM_ADDRESS}, {26'b0, exp_addr});
      chk("fill_busy", {31'b0, BUSYWAIT}, 32'd1);
      n++;
      tick();
    end
    chk("fill_cycles", n, exp_cycles);
    chk("upd_state", {30'b0, DBG_STATE}, 32'd2);
    chk("upd_mem_read", {31'b0, MEM_READ}, 32'd0);
    chk("upd_addr", {26'b0, MEM_ADDRESS}, 32'd0);
    chk("upd_busy", {31'b0, BUSYWAIT}, 32'd1);
    tick();
    chk("post_fill_state", {30'b0, DBG_STATE}, 32'd0);
  endtask

  initial begin
    RESET = 1'b0;
    PC = 32'h0;
    repeat (2) tick();
    chk("rst_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("rst_mem_read", {31'b0, MEM_READ}, 32'd0);
    chk("rst_addr", {26'b0, MEM_ADDRESS}, 32'd0);
    chk("rst_instr", INSTRUCTION, 32'h0);
    chk("rst_state", {30'b0, DBG_STATE}, 32'd0);

    // Cold miss on block 0, latency 5
    RESET = 1'b1;
    #1;
    chk("cold_busy", {31'b0, BUSYWAIT}, 32'd1);
    chk("cold_mem_read_idle", {31'b0, MEM_READ}, 32'd0);
    chk("cold_instr", INSTRUCTION, 32'h0);
    tick();
    chk("cold_state", {30'b0, DBG_STATE}, 32'd1);
    chk("cold_mem_read", {31'b0, MEM_READ}, 32'd1);
    run_fill(6'h00, 5);
    chk("hit0_instr", INSTRUCTION, 32'h00000000);
    chk("hit0_busy", {31'b0, BUSYWAIT}, 32'd0);

    PC = 32'h004; #1;
    chk("hit4_instr", INSTRUCTION, 32'h11111111);
    chk("hit4_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("hit4_mem_read", {31'b0, MEM_READ}, 32'd0);
    tick();
    PC = 32'h008; #1;
    chk("hit8_instr", INSTRUCTION, 32'h22222222);
    chk("hit8_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("hit8_mem_read", {31'b0, MEM_READ}, 32'd0);
    tick();
    PC = 32'h00C; #1;
    chk("hitc_instr", INSTRUCTION, 32'h33333333);
    chk("hitc_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("hitc_mem_read", {31'b0, MEM_READ}, 32'd0);
    tick();

    // Conflict: tag 1 index 0 evicts block 0
    PC = 32'h080; #1;
    chk("conf_busy", {31'b0, BUSYWAIT}, 32'd1);
    chk("conf_instr", INSTRUCTION, 32'h0);
    tick();
    chk("conf_mem_read", {31'b0, MEM_READ}, 32'd1);
    chk("conf_addr", {26'b0, MEM_ADDRESS}, 32'h08);
`ifdef ICACHE_STATS_EN
    chk("stats_hit", {16'b0, HIT_COUNT}, 32'd3);
    chk("stats_miss", {16'b0, MISS_COUNT}, 32'd2);
`endif
    run_fill(6'h08, 5);
    PC = 32'h084; #1;
    chk("conf_hit_instr", INSTRUCTION, 32'h11191111);
    chk("conf_hit_busy", {31'b0, BUSYWAIT}, 32'd0);
    PC = 32'h000; #1;
    chk("evict_busy", {31'b0, BUSYWAIT}, 32'd1);
    tick();
    chk("evict_addr", {26'b0, MEM_ADDRESS}, 32'h00);
    tick();
    chk("evict_mem_read2", {31'b0, MEM_READ}, 32'd1);

    // Reset in the middle of the fill
    RESET = 1'b0; #1;
    chk("midrst_mem_read", {31'b0, MEM_READ}, 32'd0);
    chk("midrst_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("midrst_addr", {26'b0, MEM_ADDRESS}, 32'd0);
    chk("midrst_state", {30'b0, DBG_STATE}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("midrst_hitcnt", {16'b0, HIT_COUNT}, 32'd0);
`endif
    repeat (2) tick();
    PC = 32'h080;
    RESET = 1'b1; #1;
    chk("postrst_busy", {31'b0, BUSYWAIT}, 32'd1);
    chk("postrst_instr", INSTRUCTION, 32'h0);
    tick();
    chk("postrst_addr", {26'b0, MEM_ADDRESS}, 32'h08);
    run_fill(6'h08, 5);
    chk("postrst_hit_instr", INSTRUCTION, 32'h00080000);

    // PC moves away while the fill is in flight
    PC = 32'h010; #1;
    chk("pcchg_busy", {31'b0, BUSYWAIT}, 32'd1);
    tick();
    chk("pcchg_addr", {26'b0, MEM_ADDRESS}, 32'h01);
    tick();
    PC = 32'h020; #1;
    chk("pcchg_addr_held", {26'b0, MEM_ADDRESS}, 32'h01);
    run_fill(6'h01, 4);
    chk("pcchg_new_busy", {31'b0, BUSYWAIT}, 32'd1);
    chk("pcchg_new_mem_read", {31'b0, MEM_READ}, 32'd0);
    mem_lat = 1;
    tick();
    chk("pcchg_new_addr", {26'b0, MEM_ADDRESS}, 32'h02);
    run_fill(6'h02, 2);
    chk("blk2_instr", INSTRUCTION, 32'h00020000);
    chk("blk2_busy", {31'b0, BUSYWAIT}, 32'd0);

    // Ignored PC bits alias onto block 1 word 1
    PC = 32'hFFFFFC17; #1;
    chk("alias_instr", INSTRUCTION, 32'h11121111);
    chk("alias_busy", {31'b0, BUSYWAIT}, 32'd0);
    PC = 32'h088; #1;
    chk("blk8_w2_instr", INSTRUCTION, 32'h222A2222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the CPU's PC output and the instruction memory; it supplies the CPU's INSTRUCTION input.
- On a hit, the instruction is returned combinationally in the same cycle as PC.
- On a miss, BUSYWAIT stalls the CPU while a 128-bit block is fetched from instruction memory over a read/busywait handshake.

Parameters:
- INDEX_BITS, 3, number of index bits; the cache holds 2^INDEX_BITS lines of 16 bytes (4 words).
- ADDR_BITS, 10, number of byte-address bits of instruction memory that are used; tag width = ADDR_BITS-4-INDEX_BITS.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  32  byte address of the instruction from the CPU PC.
- INSTRUCTION  out  32  instruction word to the CPU decoder.
- BUSYWAIT  out  1  stall request to the CPU; high while INSTRUCTION is not valid.
- MEM_READ  out  1  read request to instruction memory.
- MEM_ADDRESS  out  ADDR_BITS-4  block address {tag,index} sent to memory.
- MEM_READDATA  in  128  block data from memory; word0 is in bits [31:0].
- MEM_BUSYWAIT  in  1  memory busy; data is valid in the cycle it is low after a request.

Behaviour:
- Address split:
  - offset = PC[3:2]
  - index = PC[3+INDEX_BITS:4]
  - tag = PC[ADDR_BITS-1:4+INDEX_BITS]
  - PC[1:0] and PC bits above ADDR_BITS-1 are ignored.
- Storage per line: valid bit, tag, 128-bit data. No dirty bits; the cache is read-only.
- hit = valid[index] && (tag_store[index] == tag). This is combinational on PC.
- INSTRUCTION = selected word of line[index] when state is IDLE and hit; otherwise 32'h0.
- BUSYWAIT = (state != IDLE) || !hit. Forced to 0 while RESET is low.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE: on a miss, latch tag/index into miss_tag/miss_index at the rising edge, then go to MEM_READ. On a hit, stay in IDLE.
  - MEM_READ:
    - MEM_READ=1 and MEM_ADDRESS={miss_tag,miss_index}, both held stable for the whole state.
    - MEM_BUSYWAIT is ignored in the first cycle of the state.
    - At the first later rising edge where MEM_BUSYWAIT==0, capture MEM_READDATA into the fill buffer and go to UPDATE.
  - UPDATE:
    - MEM_READ=0.
    - At the rising edge, write the fill buffer, miss_tag and valid=1 into line[miss_index], then go to IDLE.
- Miss timing: 1 detect cycle + (memory latency, at least 2 cycles in MEM_READ) + 1 UPDATE cycle. A hit is seen in the first IDLE cycle after the fill.
- Outputs outside MEM_READ: MEM_READ=0 and MEM_ADDRESS=0.
- PC change during a fill: the fill completes for the latched miss address. The new PC is evaluated in IDLE afterwards.
- A fill to an occupied line replaces it unconditionally.
- Reset (asynchronous, any state, including mid-fill):
  - state=IDLE, all valid=0, MEM_READ=0, MEM_ADDRESS=0, fill buffer=0, INSTRUCTION=0, BUSYWAIT=0.
  - Any memory response after reset is ignored.
  - Tag and data arrays need not be cleared.
- After reset is released, the first access always misses.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds output ports HIT_COUNT[15:0] and MISS_COUNT[15:0].
  - HIT_COUNT increments at each rising edge where state==IDLE and hit.
  - MISS_COUNT increments at each IDLE->MEM_READ transition.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Cold miss: memory latency 5 cycles, RESET released, PC=0x000, block0 = {0x33333333,0x22222222,0x11111111,0x00000000} -> BUSYWAIT=1 immediately; MEM_READ=1 with MEM_ADDRESS=0x00 until completion; after UPDATE, INSTRUCTION=0x00000000 and BUSYWAIT=0.
- Same-block hits: PC=0x004, 0x008, 0x00C after the fill -> INSTRUCTION=0x11111111, 0x22222222, 0x33333333 with BUSYWAIT=0 and MEM_READ=0 throughout.
- Conflict eviction: PC=0x080 (tag 1, index 0) -> miss and refill of line 0 with MEM_ADDRESS=0x08; PC=0x000 then misses again.
- Reset mid-fill: RESET low during MEM_READ -> MEM_READ=0 and BUSYWAIT=0 immediately; a later PC=0x080 misses, proving valid bits were cleared.
- PC change during fill: PC switches from 0x010 to 0x020 while in MEM_READ -> MEM_ADDRESS stays 0x01; after UPDATE, a new miss starts with MEM_ADDRESS=0x02.
- Stats (ICACHE_STATS_EN): cold miss + 3 hits + 1 conflict miss -> HIT_COUNT=3, MISS_COUNT=2.
